// File: rtl/t_demux_1x25_loader_pkg.sv
// Shared definitions for the 5x5 window loader and the 25:1 byte-select mux users.
// Holds the loader state encoding and the default window geometry.
package t_demux_1x25_loader_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_e;

  localparam int WIN_N = 25;
  localparam int PIX_W = 8;
  localparam int SEL_W = 5;

  // One-hot write strobe for a given slot; no bit is set when en is low.
  function automatic logic [WIN_N-1:0] slot_onehot(input logic en, input logic [SEL_W-1:0] idx);
    logic [WIN_N-1:0] oh;
    oh = '0;
    for (int k = 0; k < WIN_N; k++) begin
      oh[k] = en && (idx == SEL_W'(k));
    end
    return oh;
  endfunction

endpackage

// File: rtl/t_demux_1x25_loader_ctrl.sv
// Loader control: FILL/FULL state machine, fill counter and one-hot write-enable decode.
// The write enable already accounts for flush priority and the FULL write block.
module t_loader_ctrl #(
  parameter int N     = t_demux_1x25_loader_pkg::WIN_N,
  parameter int SEL_W = t_demux_1x25_loader_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  logic             frame_ack,
  output logic             in_ready,
  output logic             frame_valid,
  output logic [SEL_W-1:0] fill_cnt,
  output logic [N-1:0]     we
);

  import t_demux_1x25_loader_pkg::*;

  loader_state_e    state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             write;

  assign in_ready    = (state_q == FILL) && !reset;
  assign frame_valid = (state_q == FULL);
  assign fill_cnt    = cnt_q;
  assign accept      = in_valid && in_ready;
  // A flushed sample is dropped even though the handshake completed.
  assign write       = accept && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (flush) begin
          cnt_d = '0;
        end else if (accept) begin
          if (cnt_q == SEL_W'(N-1)) begin
            cnt_d   = SEL_W'(N);
            state_d = FULL;
          end else begin
            cnt_d = cnt_q + SEL_W'(1);
          end
        end
      end
      FULL: begin
        if (frame_ack) begin
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    we = '0;
    for (int k = 0; k < N; k++) begin
      we[k] = write && (cnt_q == SEL_W'(k));
    end
  end

endmodule

// File: rtl/t_demux_1x25_loader.sv
// Gathers a stream of samples into an N-entry register bank (one 5x5 window) and
// presents every entry in parallel on y_flat once the frame is complete.
module t_demux_1x25_loader #(
  parameter int N     = t_demux_1x25_loader_pkg::WIN_N,
  parameter int W     = t_demux_1x25_loader_pkg::PIX_W,
  parameter int SEL_W = t_demux_1x25_loader_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             flush,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic [SEL_W-1:0] fill_cnt,
  output logic [N*W-1:0]   y_flat
);

  import t_demux_1x25_loader_pkg::*;

  logic [N-1:0] we;
  logic [W-1:0] entry [N];

  t_loader_ctrl #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .flush       (flush),
    .frame_ack   (frame_ack),
    .in_ready    (in_ready),
    .frame_valid (frame_valid),
    .fill_cnt    (fill_cnt),
    .we          (we)
  );

  // Entries not being written keep their value, including across frame_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        entry[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (we[k]) begin
          entry[k] <= in_data;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign y_flat[g*W +: W] = entry[g];
  end

endmodule

// File: tb/tb_t_demux_1x25_loader.sv
// Self-checking bench for the window loader: vector table, hand sequences for the
// multi-cycle corner cases, and randomized frames against a behavioural model.
module tb_t_demux_1x25_loader;

  import t_demux_1x25_loader_pkg::*;

  localparam int N  = WIN_N;
  localparam int W  = PIX_W;
  localparam int SW = SEL_W;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            flush;
  logic            frame_valid;
  logic            frame_ack;
  logic [SW-1:0]   fill_cnt;
  logic [N*W-1:0]  y_flat;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain array of samples, a count and a full flag.
  logic [W-1:0] m_entry [N];
  int           m_cnt;
  bit           m_full;

  typedef struct {
    bit          rst;
    bit          v;
    bit          fl;
    bit          ack;
    logic [7:0]  d;
    int          exp_cnt;
    bit          exp_fv;
    bit          exp_rdy;
    logic [7:0]  exp_e0;
    logic [7:0]  exp_e1;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  t_demux_1x25_loader dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .flush       (flush),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .fill_cnt    (fill_cnt),
    .y_flat      (y_flat)
  );

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] model_flat();
    logic [N*W-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = m_entry[k];
    return f;
  endfunction

  function automatic logic [W-1:0] dut_entry(input int k);
    return y_flat[k*W +: W];
  endfunction

  task automatic checkOutput(input string tag);
    check({tag, ".fill_cnt"},    (N*W)'(fill_cnt),    (N*W)'(m_cnt));
    check({tag, ".frame_valid"}, (N*W)'(frame_valid), (N*W)'(m_full));
    check({tag, ".in_ready"},    (N*W)'(in_ready),    (N*W)'(!m_full && !reset));
    check({tag, ".y_flat"},      y_flat,              model_flat());
  endtask

  // Drive one cycle, advance the model by the same rules, then sample after the edge.
  task automatic applyStimulus(input bit rst, input bit v, input logic [7:0] d,
                               input bit fl, input bit ack, input string tag, output bit acc);
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    frame_ack = ack;
    acc = v && !m_full && !rst && !fl;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int k = 0; k < N; k++) m_entry[k] = '0;
      m_cnt  = 0;
      m_full = 0;
    end else if (!m_full) begin
      if (fl) m_cnt = 0;
      else if (v) begin
        m_entry[m_cnt] = d;
        m_cnt++;
        if (m_cnt == N) m_full = 1;
      end
    end else if (ack) begin
      m_full = 0;
      m_cnt  = 0;
    end
    checkOutput(tag);
  endtask

  initial begin
    bit          acc;
    int          frames;
    int          cyc;
    int          ack_delay;
    bit          verified;
    logic [7:0]  next_data;
    logic [7:0]  sent_q [$];
    logic [N*W-1:0] exp_flat;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; frame_ack = 1'b0;
    for (int k = 0; k < N; k++) m_entry[k] = '0;
    m_cnt = 0; m_full = 0;

    // Short table: reset, two accepts, ack in FILL ignored, flush drops sample, reload
    vecs[0] = '{1,0,0,0,8'h00, 0,0,0, 8'h00,8'h00};
    vecs[1] = '{0,1,0,0,8'h11, 1,0,1, 8'h11,8'h00};
    vecs[2] = '{0,1,0,0,8'h22, 2,0,1, 8'h11,8'h22};
    vecs[3] = '{0,0,0,1,8'h99, 2,0,1, 8'h11,8'h22};
    vecs[4] = '{0,1,1,0,8'h55, 0,0,1, 8'h11,8'h22};
    vecs[5] = '{0,1,0,0,8'h33, 1,0,1, 8'h33,8'h22};
    vecs[6] = '{0,0,0,0,8'h77, 1,0,1, 8'h33,8'h22};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].fl, vecs[i].ack, "tbl", acc);
      check("tbl.cnt", (N*W)'(fill_cnt),    (N*W)'(vecs[i].exp_cnt));
      check("tbl.fv",  (N*W)'(frame_valid), (N*W)'(vecs[i].exp_fv));
      check("tbl.rdy", (N*W)'(in_ready),    (N*W)'(vecs[i].exp_rdy));
      check("tbl.e0",  (N*W)'(dut_entry(0)), (N*W)'(vecs[i].exp_e0));
      check("tbl.e1",  (N*W)'(dut_entry(1)), (N*W)'(vecs[i].exp_e1));
    end

    // Full frame 0x00..0x18
    applyStimulus(1, 0, 8'h00, 0, 0, "t1.rst", acc);
    for (int k = 0; k < N; k++) begin
      check("t1.fv_before_last", (N*W)'(frame_valid), '0);
      applyStimulus(0, 1, 8'(k), 0, 0, "t1.load", acc);
    end
    for (int k = 0; k < N; k++) exp_flat[k*W +: W] = 8'(k);
    check("t1.y_flat", y_flat, exp_flat);
    check("t1.fv", (N*W)'(frame_valid), (N*W)'(1));
    check("t1.rdy", (N*W)'(in_ready), '0);

    // FULL blocks writes and ignores flush; only ack leaves
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 8'hFF, (i == 5), 0, "t2.hold", acc);
    check("t2.y_flat", y_flat, exp_flat);
    check("t2.cnt", (N*W)'(fill_cnt), (N*W)'(25));
    applyStimulus(0, 0, 8'h00, 0, 1, "t2.ack", acc);
    check("t2.fv", (N*W)'(frame_valid), '0);
    check("t2.rdy", (N*W)'(in_ready), (N*W)'(1));
    check("t2.cnt0", (N*W)'(fill_cnt), '0);

    // Partial frame then flush with a same-cycle sample
    for (int k = 0; k < 7; k++) applyStimulus(0, 1, 8'hA0 + 8'(k), 0, 0, "t3.load", acc);
    applyStimulus(0, 1, 8'h55, 1, 0, "t3.flush", acc);
    check("t3.cnt", (N*W)'(fill_cnt), '0);
    check("t3.e7", (N*W)'(dut_entry(7)), (N*W)'(8'h07));
    for (int k = 0; k < N; k++) applyStimulus(0, 1, 8'h30 + 8'(k), 0, 0, "t3.reload", acc);
    check("t3.e0", (N*W)'(dut_entry(0)), (N*W)'(8'h30));
    check("t3.fv", (N*W)'(frame_valid), (N*W)'(1));
    applyStimulus(0, 0, 8'h00, 0, 1, "t3.ack", acc);

    // Reset mid-frame and in FULL
    for (int k = 0; k < 12; k++) applyStimulus(0, 1, 8'hC0 + 8'(k), 0, 0, "t5.load", acc);
    applyStimulus(1, 1, 8'hEE, 0, 0, "t5.rst_mid", acc);
    applyStimulus(0, 0, 8'h00, 0, 0, "t5.idle", acc);
    check("t5.mid.y_flat", y_flat, '0);
    check("t5.mid.rdy", (N*W)'(in_ready), (N*W)'(1));
    for (int k = 0; k < N; k++) applyStimulus(0, 1, 8'hD0 + 8'(k), 0, 0, "t5.fill", acc);
    applyStimulus(1, 0, 8'h00, 0, 0, "t5.rst_full", acc);
    applyStimulus(0, 0, 8'h00, 0, 0, "t5.idle2", acc);
    check("t5.full.y_flat", y_flat, '0);
    check("t5.full.fv", (N*W)'(frame_valid), '0);
    check("t5.full.cnt", (N*W)'(fill_cnt), '0);

    // Ack during FILL has no effect
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 8'h60 + 8'(k), 0, 0, "t6.load", acc);
    applyStimulus(0, 0, 8'h00, 0, 1, "t6.ack", acc);
    check("t6.cnt", (N*W)'(fill_cnt), (N*W)'(3));
    for (int k = 3; k < N; k++) applyStimulus(0, 1, 8'h60 + 8'(k), 0, 0, "t6.rest", acc);
    check("t6.fv", (N*W)'(frame_valid), (N*W)'(1));
    applyStimulus(0, 0, 8'h00, 0, 1, "t6.done", acc);

    // Random gaps over three frames, scoreboarded by accepted-sample order
    applyStimulus(1, 0, 8'h00, 0, 0, "t4.rst", acc);
    frames = 0; cyc = 0; verified = 0; ack_delay = 0; next_data = 8'h80;
    while (frames < 3 && cyc < 3000) begin
      cyc++;
      if (m_full) begin
        if (!verified) begin
          for (int k = 0; k < N; k++) exp_flat[k*W +: W] = sent_q.pop_front();
          check("t4.frame", y_flat, exp_flat);
          verified  = 1;
          ack_delay = int'($urandom_range(0, 3));
        end
        if (ack_delay == 0) begin
          applyStimulus(0, 1'($urandom_range(0, 1)), 8'hEE, 0, 1, "t4.ack", acc);
          frames++;
          verified = 0;
        end else begin
          ack_delay--;
          applyStimulus(0, 1, 8'hEE, 0, 0, "t4.wait", acc);
        end
      end else begin
        applyStimulus(0, 1'($urandom_range(0, 1)), next_data, 0, 0, "t4.feed", acc);
        if (acc) begin
          sent_q.push_back(next_data);
          next_data++;
        end
      end
    end
    check("t4.frames", (N*W)'(frames), (N*W)'(3));
    check("t4.leftover", (N*W)'(sent_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
